// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: instruction field positions, the NOP
// encoding and the {pc_4, ins} entry type held by the IF/ID queue.
package mips_pkg;

  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int J_HI   = 25;
  localparam int J_LO   = 0;

  localparam logic [31:0] NOP_INS = 32'h0;

  // One queue entry as it appears at the default widths.
  typedef struct packed {
    logic [29:0] pc_4;
    logic [31:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf_d_if.sv
// Bundle of fetch-side handshake and decode-side outputs of the IF/ID queue.
// master = fetch/decode environment, slave = the queue itself.
interface fetch_buf_d_if #(
  parameter int DEPTH = 4,
  parameter int INS_W = 32,
  parameter int PC_W  = 30,
  parameter int CNT_W = $clog2(DEPTH) + 1
);

  logic             in_valid;
  logic             in_ready;
  logic [INS_W-1:0] ins_i;
  logic [PC_W-1:0]  pc_4_i;
  logic             flush;
  logic             stop_D;
  logic             valid_D;
  logic [INS_W-1:0] ins_D;
  logic [PC_W-1:0]  pc_4_D;
  logic [4:0]       rs_D;
  logic [4:0]       rt_D;
  logic [4:0]       rd_D;
  logic [4:0]       s_D;
  logic [15:0]      imm_D;
  logic [25:0]      j_D;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, ins_i, pc_4_i, flush, stop_D,
    input  in_ready, valid_D, ins_D, pc_4_D, rs_D, rt_D, rd_D, s_D, imm_D, j_D, count
  );

  modport slave (
    input  in_valid, ins_i, pc_4_i, flush, stop_D,
    output in_ready, valid_D, ins_D, pc_4_D, rs_D, rt_D, rd_D, s_D, imm_D, j_D, count
  );

endinterface

// File: rtl/fetch_buf_mem.sv
// Entry storage for the IF/ID queue: synchronous write, combinational read
// so the head entry falls through to decode without an extra cycle.
module fetch_buf_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 62,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem_reg [DEPTH];

  // Write the tail entry; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Head entry is read asynchronously.
  always_comb begin
    rd_data = mem_reg[rd_addr];
  end

endmodule

// File: rtl/fetch_buf_d.sv
// IF/ID boundary: DEPTH-entry first-word-fall-through queue of {pc_4, ins}
// with a valid/ready handshake toward fetch, a redirect flush, and decode
// field slicing of the head. An empty queue presents a NOP bubble.
module fetch_buf_d
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int INS_W = 32,
  parameter int PC_W  = 30,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  fetch_buf_d_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = PC_W + INS_W;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic             full;
  logic             valid;
  logic             enq;
  logic             deq;
  logic             wr_en;
  logic [ENT_W-1:0] head_entry;
  logic [INS_W-1:0] ins_masked;
  logic [PC_W-1:0]  pc_masked;

  // Handshake terms; in_ready looks only at occupancy, never at stop_D.
  always_comb begin
    full  = (count_reg == CNT_W'(DEPTH));
    valid = (count_reg != '0);
    enq   = bus.in_valid & ~full;
    deq   = valid & ~bus.stop_D;
    wr_en = enq & ~bus.flush & ~rst;
  end

  fetch_buf_mem #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (tail_reg),
    .wr_data ({bus.pc_4_i, bus.ins_i}),
    .rd_addr (head_reg),
    .rd_data (head_entry)
  );

  // Pointer and occupancy update; reset beats flush, flush beats enq/deq.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (bus.flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (deq) head_reg <= head_reg + PTR_W'(1);
      if (enq) tail_reg <= tail_reg + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Present the head entry, forced to a NOP bubble when empty.
  always_comb begin
    ins_masked = valid ? head_entry[INS_W-1:0] : INS_W'(NOP_INS);
    pc_masked  = valid ? head_entry[ENT_W-1:INS_W] : '0;
  end

  // Decode-side outputs; fields are slices of the masked instruction.
  always_comb begin
    bus.in_ready = ~full;
    bus.valid_D  = valid;
    bus.ins_D    = ins_masked;
    bus.pc_4_D   = pc_masked;
    bus.rs_D     = ins_masked[RS_HI:RS_LO];
    bus.rt_D     = ins_masked[RT_HI:RT_LO];
    bus.rd_D     = ins_masked[RD_HI:RD_LO];
    bus.s_D      = ins_masked[SH_HI:SH_LO];
    bus.imm_D    = ins_masked[IMM_HI:IMM_LO];
    bus.j_D      = ins_masked[J_HI:J_LO];
    bus.count    = count_reg;
  end

endmodule

// File: tb/tb_fetch_buf_d.sv
// Bench for fetch_buf_d: directed phases then random traffic, checked
// against a queue-based reference model by a negedge monitor.
module tb_fetch_buf_d;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_buf_d_if #(.DEPTH(DEPTH), .INS_W(32), .PC_W(30)) bus_if ();

  fetch_buf_d #(.DEPTH(DEPTH), .INS_W(32), .PC_W(30), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 0;

  fetch_entry_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a plain FIFO of accepted entries, updated at each edge.
  always @(posedge clk) begin
    bit take;
    bit give;
    fetch_entry_t e;
    if (rst) begin
      exp_q.delete();
      started = 1;
    end else if (started) begin
      if (bus_if.flush) begin
        exp_q.delete();
      end else begin
        take = bus_if.in_valid && (exp_q.size() < DEPTH);
        give = (exp_q.size() != 0) && !bus_if.stop_D;
        e.pc_4 = bus_if.pc_4_i;
        e.ins  = bus_if.ins_i;
        if (give) void'(exp_q.pop_front());
        if (take) exp_q.push_back(e);
      end
    end
  end

  // Monitor: compare the presented head and status against the model.
  always @(negedge clk) begin
    fetch_entry_t h;
    if (started && !rst) begin
      chk("count", 64'(bus_if.count), 64'(exp_q.size()));
      chk("in_ready", 64'(bus_if.in_ready), 64'(exp_q.size() < DEPTH));
      chk("valid_D", 64'(bus_if.valid_D), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        h = exp_q[0];
        chk("ins_D", 64'(bus_if.ins_D), 64'(h.ins));
        chk("pc_4_D", 64'(bus_if.pc_4_D), 64'(h.pc_4));
        chk("rs_D", 64'(bus_if.rs_D), 64'((h.ins >> 21) & 32'h1f));
        chk("rt_D", 64'(bus_if.rt_D), 64'((h.ins >> 16) & 32'h1f));
        chk("rd_D", 64'(bus_if.rd_D), 64'((h.ins >> 11) & 32'h1f));
        chk("s_D", 64'(bus_if.s_D), 64'((h.ins >> 6) & 32'h1f));
        chk("imm_D", 64'(bus_if.imm_D), 64'(h.ins & 32'hffff));
        chk("j_D", 64'(bus_if.j_D), 64'(h.ins & 32'h3ffffff));
      end else begin
        chk("bubble", {bus_if.ins_D, bus_if.pc_4_D, 2'b00},  64'h0);
        chk("bubble_fields",
            64'({bus_if.rs_D, bus_if.rt_D, bus_if.rd_D, bus_if.s_D, bus_if.imm_D, bus_if.j_D}), 64'h0);
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] ins, input logic [29:0] pc,
                      input bit stop, input bit fl);
    bus_if.in_valid = v;
    bus_if.ins_i    = ins;
    bus_if.pc_4_i   = pc;
    bus_if.stop_D   = stop;
    bus_if.flush    = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.ins_i    = 32'h8C220004;
    bus_if.pc_4_i   = 30'h0;
    bus_if.stop_D   = 1'b0;
    bus_if.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", 64'(bus_if.valid_D), 64'h0);
    chk("reset_ins", 64'(bus_if.ins_D), 64'h0);
    chk("reset_count", 64'(bus_if.count), 64'h0);
    chk("reset_ready", 64'(bus_if.in_ready), 64'h1);

    // Single pass
    step(1, 32'h8C220004, 30'h401, 0, 0);
    chk("sp_valid", 64'(bus_if.valid_D), 64'h1);
    chk("sp_rs", 64'(bus_if.rs_D), 64'h1);
    chk("sp_rt", 64'(bus_if.rt_D), 64'h2);
    chk("sp_imm", 64'(bus_if.imm_D), 64'h4);
    chk("sp_pc", 64'(bus_if.pc_4_D), 64'h401);
    step(0, 32'h0, 30'h0, 0, 0);
    chk("sp_after_valid", 64'(bus_if.valid_D), 64'h0);
    chk("sp_after_ins", 64'(bus_if.ins_D), 64'h0);

    // Fill while stalled; fifth word must be refused
    for (int i = 0; i < 4; i++) step(1, 32'hA0000000 + 32'(i), 30'(16 + i), 1, 0);
    chk("fill_count", 64'(bus_if.count), 64'h4);
    chk("fill_ready", 64'(bus_if.in_ready), 64'h0);
    step(1, 32'hEEEEEEEE, 30'h1E, 1, 0);
    chk("fill_e_dropped", 64'(bus_if.count), 64'h4);
    chk("fill_head", 64'(bus_if.ins_D), 64'hA0000000);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 30'h0, 0, 0);

    // Wrap with stop toggling
    for (int i = 0; i < 10; i++) step(1, 32'hB0000000 + 32'(i), 30'(32 + i), (i % 2) == 0, 0);
    for (int i = 0; i < 8; i++) step(0, 32'h0, 30'h0, 0, 0);

    // Flush with three entries queued plus a same-cycle enqueue
    for (int i = 0; i < 3; i++) step(1, 32'hC0000000 + 32'(i), 30'(48 + i), 1, 0);
    step(1, 32'hDEADBEEF, 30'h3F, 1, 1);
    chk("flush_count", 64'(bus_if.count), 64'h0);
    chk("flush_valid", 64'(bus_if.valid_D), 64'h0);
    step(1, 32'h12345678, 30'h55, 1, 0);
    chk("post_flush_ins", 64'(bus_if.ins_D), 64'h12345678);
    step(0, 32'h0, 30'h0, 0, 1);

    // Simultaneous enqueue and dequeue at count 2
    step(1, 32'h11110000, 30'h60, 1, 0);
    step(1, 32'h22220000, 30'h61, 1, 0);
    chk("sim_count_pre", 64'(bus_if.count), 64'h2);
    step(1, 32'h33330000, 30'h62, 0, 0);
    chk("sim_count", 64'(bus_if.count), 64'h2);
    chk("sim_head", 64'(bus_if.ins_D), 64'h22220000);
    for (int i = 0; i < 4; i++) step(0, 32'h0, 30'h0, 0, 0);

    // Random traffic including occasional flush and reset
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step($urandom_range(0, 3) != 0, $urandom, 30'($urandom),
           $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(0, 32'h0, 30'h0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buf_d.md
Name: fetch_buf_d

Overview:
Parametrised IF/ID boundary for the MIPS pipeline. It replaces the single-entry decode register with a DEPTH-entry first-word-fall-through instruction queue, adding a valid/ready handshake toward fetch and a flush input for branch/jump redirect. It holds {pc_4, ins} pairs, presents the head entry to decode, and slices the head into rs/rt/rd/imm/j/shamt fields. When the queue is empty it outputs a NOP bubble.

Parameters:
DEPTH, 4, number of queue entries; power of 2, at least 2.
INS_W, 32, instruction width.
PC_W, 30, width of pc_4 (bits [31:2] of PC+4).
CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  fetch presents a valid {pc_4_i, ins_i}.
in_ready  out  1  queue can accept an entry this cycle.
ins_i  in  INS_W  fetched instruction.
pc_4_i  in  PC_W  PC+4 of the fetched instruction.
flush  in  1  discard all queued entries (redirect).
stop_D  in  1  decode stall; the head entry is held.
valid_D  out  1  the head entry is a real instruction.
ins_D  out  INS_W  head instruction; 0 (NOP) when valid_D=0.
pc_4_D  out  PC_W  head PC+4; 0 when valid_D=0.
rs_D  out  5  ins_D[25:21].
rt_D  out  5  ins_D[20:16].
rd_D  out  5  ins_D[15:11].
s_D  out  5  ins_D[10:6].
imm_D  out  16  ins_D[15:0].
j_D  out  26  ins_D[25:0].
count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset: the clock and reset are fixed as follows. There is one clock, clk. Reset rst is synchronous and active-high.
- When rst is sampled at 1: head pointer, tail pointer and count go to 0. After that edge, valid_D=0, ins_D=0, pc_4_D=0, all field outputs are 0, and in_ready=1. Storage contents are not cleared.
- Reset mid-operation drops all entries. It overrides flush, enqueue and dequeue in the same cycle.
- Enqueue (enq) = in_valid & in_ready. The entry is written at the tail, and tail advances modulo DEPTH.
- in_ready = (count != DEPTH). in_ready does not depend on the same-cycle dequeue, so there is no combinational path from stop_D to in_ready.
- Dequeue (deq) = valid_D & ~stop_D. Head advances modulo DEPTH.
- valid_D = (count != 0). Outputs are combinational from the head entry and forced to 0 when the queue is empty.
- Latency: an entry enqueued at edge N is visible on the outputs after edge N, i.e. one cycle. There is no same-cycle bypass from ins_i to ins_D.
- Simultaneous enq and deq: count is unchanged, and both pointers advance.
- Full with deq in the same cycle: in_ready is already 0, so no enqueue happens. Count becomes DEPTH-1.
- Flush: at the edge, head=tail=0 and count=0. Any same-cycle enqueue is discarded. Flush takes priority over stop_D and enq. valid_D=0 in the following cycle.
- stop_D while empty: no effect. Enqueue continues until the queue is full.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Count is kept separately, so full and empty are distinguished by count.
- Field outputs are slices of the masked ins_D, so all fields are 0 during a bubble.

Decomposition:
- Shared package mips_pkg holds:
  - field bit-position constants (RS_HI/LO, RT_HI/LO, RD_HI/LO, SH_HI/LO, IMM_HI/LO, J_HI/LO);
  - NOP_INS = 32'h0;
  - a typedef for the {pc_4, ins} entry.
- Sub-module fetch_buf_mem: DEPTH x (PC_W+INS_W) register array with a synchronous write port and a combinational read port.
- Pointer, count and flush control, plus field slicing, stay in fetch_buf_d.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 and ins_i=32'h8C220004 -> after release, valid_D=0, ins_D=0, count=0, in_ready=1.
- Single pass: enqueue ins_i=32'h8C220004, pc_4_i=30'h00000401, stop_D=0 -> next cycle valid_D=1, rs_D=1, rt_D=2, imm_D=16'h0004, pc_4_D=30'h401. The cycle after that, valid_D=0 and ins_D=0.
- Fill and stall, DEPTH=4: stop_D=1, enqueue 5 consecutive words A..E -> count reaches 4, in_ready=0 on the 5th cycle, E is not taken. Release stop_D -> A, B, C, D emerge in order on 4 consecutive cycles.
- Wrap: stream 10 entries with stop_D toggling 1,0,1,0 -> output order matches input order exactly, with no duplicates or losses across pointer wrap.
- Flush: with count=3, assert flush together with in_valid=1 -> next cycle count=0, valid_D=0, and the flushed-cycle word never appears. The next enqueue emerges one cycle later.
- Simultaneous: with count=2, assert enq and deq together -> count stays 2 and the head advances by one entry.
